// File: rtl/div_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_seq_ctrl: signed/unsigned divide sequencer for an unsigned AXI-stream  |
// | divider IP. Optional macro DIV_ZERO_FASTPATH_EN bypasses the IP on /0.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                req_ack,
  input  logic                flush,
  output logic                dividend_tvalid,
  input  logic                dividend_tready,
  output logic [DATA_W-1:0]   dividend_tdata,
  output logic                divisor_tvalid,
  input  logic                divisor_tready,
  output logic [DATA_W-1:0]   divisor_tdata,
  input  logic                dout_tvalid,
  input  logic [2*DATA_W-1:0] dout_tdata,
  output logic                busy,
  output logic                res_valid,
  output logic [DATA_W-1:0]   res_hi,
  output logic [DATA_W-1:0]   res_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              dvd_sent_q, dvd_sent_d, dvs_sent_q, dvs_sent_d;
  logic              cancel_q, cancel_d, res_valid_q, res_valid_d;

  logic [DATA_W-1:0] src1_mag, src2_mag, quo, rem;
  logic              dvd_hs, dvs_hs, dvd_done, dvs_done, drop;

  // The IP only divides unsigned; 0x80000000 naturally stays as its own magnitude.
  assign src1_mag = (req_signed && req_src1[DATA_W-1]) ? -req_src1 : req_src1;
  assign src2_mag = (req_signed && req_src2[DATA_W-1]) ? -req_src2 : req_src2;
  assign quo      = dout_tdata[2*DATA_W-1:DATA_W];
  assign rem      = dout_tdata[DATA_W-1:0];

  always_comb begin
    state_d         = state_q;
    dvd_d           = dvd_q;
    dvs_d           = dvs_q;
    res_hi_d        = res_hi_q;
    res_lo_d        = res_lo_q;
    neg_quo_d       = neg_quo_q;
    neg_rem_d       = neg_rem_q;
    dvd_sent_d      = dvd_sent_q;
    dvs_sent_d      = dvs_sent_q;
    cancel_d        = cancel_q;
    res_valid_d     = res_valid_q;
    dividend_tvalid = (state_q == SEND) && !dvd_sent_q;
    divisor_tvalid  = (state_q == SEND) && !dvs_sent_q;
    dvd_hs          = dividend_tvalid && dividend_tready;
    dvs_hs          = divisor_tvalid && divisor_tready;
    dvd_done        = dvd_sent_q || dvd_hs;
    dvs_done        = dvs_sent_q || dvs_hs;
    drop            = cancel_q || flush;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          dvd_d      = src1_mag;
          dvs_d      = src2_mag;
          neg_quo_d  = req_signed && (req_src1[DATA_W-1] ^ req_src2[DATA_W-1]);
          neg_rem_d  = req_signed && req_src1[DATA_W-1];
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          cancel_d   = 1'b0;
`ifdef DIV_ZERO_FASTPATH_EN
          if (req_src2 == '0) begin
            res_lo_d    = '1;
            res_hi_d    = req_src1;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = SEND;
          end
`else
          state_d = SEND;
`endif
        end
      end
      SEND: begin
        dvd_sent_d = dvd_done;
        dvs_sent_d = dvs_done;
        // Once any operand reached the IP its result must be drained to keep the IP queue aligned.
        if (flush && !dvd_done && !dvs_done) begin
          state_d = IDLE;
        end else begin
          if (flush) cancel_d = 1'b1;
          if (dvd_done && dvs_done) state_d = WAIT;
        end
      end
      WAIT: begin
        if (dout_tvalid) begin
          if (drop) begin
            cancel_d = 1'b0;
            state_d  = IDLE;
          end else begin
            res_lo_d    = neg_quo_q ? -quo : quo;
            res_hi_d    = neg_rem_q ? -rem : rem;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      DONE: begin
        if (req_ack || flush) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvd_sent_q  <= 1'b0;
      dvs_sent_q  <= 1'b0;
      cancel_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dvd_sent_q  <= dvd_sent_d;
      dvs_sent_q  <= dvs_sent_d;
      cancel_q    <= cancel_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign dividend_tdata = dvd_q;
  assign divisor_tdata  = dvs_q;
  assign busy           = (state_q != IDLE);
  assign res_valid      = res_valid_q;
  assign res_hi         = res_hi_q;
  assign res_lo         = res_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// tb_div_seq_ctrl: directed test of div_seq_ctrl against a behavioural divider IP,
// with operand and result scoreboards.
module tb_div_seq_ctrl;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid, req_signed, req_ack, flush;
  logic [W-1:0]   req_src1, req_src2;
  logic           dividend_tvalid, dividend_tready, divisor_tvalid, divisor_tready;
  logic [W-1:0]   dividend_tdata, divisor_tdata;
  logic           dout_tvalid;
  logic [2*W-1:0] dout_tdata;
  logic           busy, res_valid;
  logic [W-1:0]   res_hi, res_lo;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_src1(req_src1), .req_src2(req_src2),
    .req_ack(req_ack), .flush(flush),
    .dividend_tvalid(dividend_tvalid), .dividend_tready(dividend_tready),
    .dividend_tdata(dividend_tdata),
    .divisor_tvalid(divisor_tvalid), .divisor_tready(divisor_tready),
    .divisor_tdata(divisor_tdata),
    .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata),
    .busy(busy), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   exp_dvd_q[$];
  logic [W-1:0]   exp_dvs_q[$];
  logic [2*W-1:0] exp_res_q[$];
  logic [W-1:0]   ip_dvd_q[$];
  logic [W-1:0]   ip_dvs_q[$];

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural divider IP: one result in flight, dout LAT cycles after both operands arrive.
  always @(posedge clk) begin : ip_model
    int             cnt;
    logic [2*W-1:0] res;
    logic [W-1:0]   a, b;
    if (reset) begin
      dout_tvalid <= 1'b0;
      dout_tdata  <= '0;
      cnt = 0;
      res = '0;
    end else begin
      if (dividend_tvalid && dividend_tready) begin
        if (exp_dvd_q.size() == 0) chk("unexpected_dividend_hs", 64'd1, 64'd0);
        else chk("dividend_tdata", 64'(dividend_tdata), 64'(exp_dvd_q.pop_front()));
        ip_dvd_q.push_back(dividend_tdata);
      end
      if (divisor_tvalid && divisor_tready) begin
        if (exp_dvs_q.size() == 0) chk("unexpected_divisor_hs", 64'd1, 64'd0);
        else chk("divisor_tdata", 64'(divisor_tdata), 64'(exp_dvs_q.pop_front()));
        ip_dvs_q.push_back(divisor_tdata);
      end
      if (dout_tvalid)
        chk("dout_outside_wait",
            64'(busy && !res_valid && !dividend_tvalid && !divisor_tvalid), 64'd1);
      dout_tvalid <= 1'b0;
      if (cnt == 1) begin
        dout_tvalid <= 1'b1;
        dout_tdata  <= res;
        cnt = 0;
      end else if (cnt > 1) begin
        cnt = cnt - 1;
      end else if (ip_dvd_q.size() > 0 && ip_dvs_q.size() > 0) begin
        a   = ip_dvd_q.pop_front();
        b   = ip_dvs_q.pop_front();
        res = (b == '0) ? {{W{1'b1}}, a} : {a / b, a % b};
        cnt = LAT - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ma, input logic [W-1:0] mb, input bit via_ip);
    if (via_ip) begin
      exp_dvd_q.push_back(ma);
      exp_dvs_q.push_back(mb);
    end
    req_signed = sgn;
    req_src1   = a;
    req_src2   = b;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic wait_result(output int n);
    logic [2*W-1:0] e;
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk("res_valid_timeout", 64'(res_valid), 64'd1);
    if (exp_res_q.size() == 0) begin
      chk("unexpected_result", 64'd1, 64'd0);
    end else begin
      e = exp_res_q.pop_front();
      chk("res_hi", 64'(res_hi), 64'(e[2*W-1:W]));
      chk("res_lo", 64'(res_lo), 64'(e[W-1:0]));
    end
  endtask

  task automatic ack();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    chk("ack_res_valid", 64'(res_valid), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    bit got, seen;
    reset = 1'b1;
    req_valid = 1'b0; req_signed = 1'b0; req_src1 = '0; req_src2 = '0;
    req_ack = 1'b0; flush = 1'b0;
    dividend_tready = 1'b1; divisor_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalids", 64'({dividend_tvalid, divisor_tvalid}), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res", {res_hi, res_lo}, 64'd0);

    // -7 / 2 signed, nominal latency 2+LAT
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 1'b1);
    exp_res_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_result(n);
    chk("latency", 64'(n), 64'(LAT + 1));
    repeat (2) tick();
    chk("hold_res_valid", 64'(res_valid), 64'd1);
    chk("hold_res_lo", 64'(res_lo), 64'hFFFF_FFFD);
    ack();

    issue(1'b0, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF, 32'h10, 1'b1);
    exp_res_q.push_back({32'h0000_000F, 32'h0FFF_FFFF});
    wait_result(n);
    ack();

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b1);
    exp_res_q.push_back({32'h0, 32'h8000_0000});
    wait_result(n);
    ack();

    // Staggered channel readiness: -100 / 9 signed
    dividend_tready = 1'b0; divisor_tready = 1'b0;
    issue(1'b1, 32'hFFFF_FF9C, 32'd9, 32'd100, 32'd9, 1'b1);
    exp_res_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF5});
    dividend_tready = 1'b1;
    chk("stag_c1_tvalids", 64'({dividend_tvalid, divisor_tvalid}), 64'b11);
    tick();
    dividend_tready = 1'b0;
    chk("stag_c2_tvalids", 64'({dividend_tvalid, divisor_tvalid}), 64'b01);
    chk("stag_c2_divisor_tdata", 64'(divisor_tdata), 64'd9);
    tick();
    chk("stag_c3_divisor_tvalid", 64'(divisor_tvalid), 64'd1);
    tick();
    divisor_tready = 1'b1;
    chk("stag_c4_divisor_tvalid", 64'(divisor_tvalid), 64'd1);
    tick();
    chk("stag_c5_wait", 64'({busy, res_valid, dividend_tvalid, divisor_tvalid}), 64'b1000);
    dividend_tready = 1'b1;
    wait_result(n);
    ack();

    // Flush in WAIT, with the next request held during the drain
    issue(1'b0, 32'd50, 32'd3, 32'd50, 32'd3, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_dvd_q.push_back(32'd100);
    exp_dvs_q.push_back(32'd7);
    exp_res_q.push_back({32'd2, 32'd14});
    req_signed = 1'b0; req_src1 = 32'd100; req_src2 = 32'd7; req_valid = 1'b1;
    got = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      seen |= res_valid;
      if (!busy) got = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk("flush_wait_no_res", 64'(seen), 64'd0);
    chk("drain_reached_idle", 64'(got), 64'd1);
    wait_result(n);
    ack();

    // Flush in the first SEND cycle with both channels stalled
    dividend_tready = 1'b0; divisor_tready = 1'b0;
    issue(1'b1, 32'd20, 32'd4, 32'd20, 32'd4, 1'b0);
    chk("send_flush_tvalids", 64'({dividend_tvalid, divisor_tvalid}), 64'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("send_flush_idle", 64'({busy, dividend_tvalid, divisor_tvalid}), 64'd0);
    dividend_tready = 1'b1; divisor_tready = 1'b1;
    repeat (6) tick();
    chk("send_flush_no_res", 64'({busy, res_valid}), 64'd0);

    // Flush in DONE
    issue(1'b0, 32'd9, 32'd4, 32'd9, 32'd4, 1'b1);
    exp_res_q.push_back({32'd1, 32'd2});
    wait_result(n);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_res_valid", 64'(res_valid), 64'd0);
    chk("done_flush_busy", 64'(busy), 64'd0);

    // Zero divisor: 5 / 0 signed
`ifdef DIV_ZERO_FASTPATH_EN
    issue(1'b1, 32'd5, 32'd0, 32'd5, 32'd0, 1'b0);
    exp_res_q.push_back({32'd5, 32'hFFFF_FFFF});
    wait_result(n);
    chk("fastpath_latency", 64'(n), 64'd0);
`else
    issue(1'b1, 32'd5, 32'd0, 32'd5, 32'd0, 1'b1);
    exp_res_q.push_back({32'd5, 32'hFFFF_FFFF});
    wait_result(n);
`endif
    ack();

    repeat (LAT + 2) tick();
    chk("scoreboard_empty", 64'(exp_res_q.size() + exp_dvd_q.size() + exp_dvs_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
